// File: rtl/rng_pkg.sv
// Shared constants, FSM state type and LFSR step helper for the RNG share arbiter.
package rng_pkg;

    localparam int unsigned LFSR_W = 5;
    localparam int unsigned TAP_HI = 4;
    localparam int unsigned TAP_LO = 2;
    localparam logic [LFSR_W-1:0] SEED_SAFE = 5'b00001;

    typedef enum logic [0:0] {
        StWarmup,
        StServe
    } state_e;

    // x^5 + x^3 + 1 Fibonacci step; maximal length, never reaches zero from a nonzero state.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/rng_share_arbiter_lfsr.sv
// 5-bit LFSR register: load beats step, a zero load is replaced by the safe seed.
module rng_lfsr5
    import rng_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    // State register with synchronous reset to the safe seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED_SAFE;
        end else if (load) begin
            q <= (load_val == '0) ? SEED_SAFE : load_val;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/rng_share_arbiter.sv
// Round-robin arbiter handing out one LFSR value per grant, with warm-up after reset/reseed.
module rng_share_arbiter
    import rng_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WARMUP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic              rnd_valid,
    output logic [LFSR_W-1:0] rnd_data,
    output logic              busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [3:0]        warm_cnt_q, warm_cnt_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              rnd_valid_q, rnd_valid_d;
    logic [LFSR_W-1:0] rnd_data_q, rnd_data_d;
    logic [LFSR_W-1:0] lfsr_q;
    logic              step_en;
    logic              found;
    logic [PTR_W-1:0]  sel_idx;

    rng_lfsr5 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (step_en),
        .load     (seed_valid),
        .load_val (seed),
        .q        (lfsr_q)
    );

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        logic [PTR_W-1:0] cand;
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = PTR_W'((32'(rr_ptr_q) + off) % NREQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Next-state logic; a seed load overrides any grant decision in the same cycle.
    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = '0;
        rnd_valid_d = 1'b0;
        rnd_data_d  = rnd_data_q;
        step_en     = 1'b0;
        if (seed_valid) begin
            state_d    = StWarmup;
            warm_cnt_d = '0;
        end else begin
            unique case (state_q)
                StWarmup: begin
                    step_en    = 1'b1;
                    warm_cnt_d = warm_cnt_q + 4'd1;
                    if (warm_cnt_q == 4'(WARMUP - 1)) begin
                        state_d    = StServe;
                        warm_cnt_d = '0;
                    end
                end
                StServe: begin
                    if (found) begin
                        gnt_d       = NREQ'(1) << sel_idx;
                        rnd_valid_d = 1'b1;
                        rnd_data_d  = lfsr_q;
                        step_en     = 1'b1;
                        rr_ptr_d    = PTR_W'((32'(sel_idx) + 1) % NREQ);
                    end
                end
                default: state_d = StWarmup;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StWarmup;
            warm_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = rnd_data_q;
    assign busy      = (state_q == StWarmup);

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants, a negedge monitor pops and compares.
module tb_rng_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       seed_valid;
    logic [4:0] seed;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       rnd_valid;
    logic [4:0] rnd_data;
    logic       busy;

    typedef struct packed {
        logic [3:0] g;
        logic [4:0] d;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] seen_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    rng_share_arbiter #(.NREQ(4), .WARMUP(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed       (seed),
        .req        (req),
        .gnt        (gnt),
        .rnd_valid  (rnd_valid),
        .rnd_data   (rnd_data),
        .busy       (busy)
    );

    function automatic logic [4:0] model_next(input logic [4:0] s);
        return {s[3:0], s[4] ^ s[2]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [4:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // busy must stay high for exactly 4 visible cycles; caller has just passed the first edge.
    task automatic warm_check(input string tag);
        check({tag, "_busy0"}, busy, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check({tag, "_busy"}, busy, 1);
        end
        tick();
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_lfsr"}, dut.u_lfsr.q, 5'b10010);
    endtask

    // Monitor: every presented grant must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            check("valid_eq_or_gnt", rnd_valid, |gnt);
            if (rnd_valid) begin
                seen_q.push_back(rnd_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant got gnt=%b data=%b want none", gnt, rnd_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("gnt", gnt, e.g);
                    check("rnd_data", rnd_data, e.d);
                end
            end
        end
    end

    initial begin
        logic [4:0] v;
        rst = 1'b1; seed_valid = 1'b0; seed = '0; req = '0;
        tick();
        tick();
        mon_en = 1'b1;
        check("rst_gnt", gnt, 0);
        check("rst_valid", rnd_valid, 0);
        check("rst_data", rnd_data, 0);
        check("rst_lfsr", dut.u_lfsr.q, 5'b00001);
        rst = 1'b0;
        warm_check("init");

        // Two requesters, rr_ptr starts at 0.
        push(4'b0010, 5'b10010);
        push(4'b1000, 5'b00101);
        push(4'b0010, 5'b01011);
        req = 4'b1010;
        repeat (3) tick();
        req = '0;
        tick();
        check("drain_alt", exp_q.size(), 0);

        // Fresh reset, all four requesting: full rotation with wrap.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        warm_check("rst2");
        push(4'b0001, 5'b10010);
        push(4'b0010, 5'b00101);
        push(4'b0100, 5'b01011);
        push(4'b1000, 5'b10110);
        push(4'b0001, 5'b01100);
        req = 4'b1111;
        repeat (5) tick();
        req = '0;
        tick();
        check("drain_all", exp_q.size(), 0);

        // Idle gap: no LFSR step while nobody requests.
        repeat (3) tick();
        push(4'b0001, 5'b11001);
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        check("drain_idle", exp_q.size(), 0);

        // Zero seed with a competing request in the same cycle.
        seed_valid = 1'b1;
        seed = 5'b00000;
        req = 4'b0001;
        tick();
        seed_valid = 1'b0;
        check("seed_gnt", gnt, 0);
        check("seed_valid_out", rnd_valid, 0);
        warm_check("seed");

        // Full period: 32 consecutive grants to requester 0.
        seen_q.delete();
        v = 5'b10010;
        for (int k = 0; k < 32; k++) begin
            push(4'b0001, v);
            v = model_next(v);
        end
        repeat (32) tick();
        req = '0;
        tick();
        check("drain_period", exp_q.size(), 0);
        check("period_count", seen_q.size(), 32);
        if (seen_q.size() == 32) begin
            check("period_first", seen_q[0], 5'b10010);
            check("period_wrap", seen_q[31], seen_q[0]);
            for (int i = 0; i < 31; i++) begin
                checks++;
                if (seen_q[i] == 5'd0) begin
                    errors++;
                    $display("FAIL period_nonzero idx %0d got %b want nonzero", i, seen_q[i]);
                end
                for (int j = i + 1; j < 31; j++) begin
                    if (seen_q[i] == seen_q[j]) begin
                        errors++;
                        $display("FAIL period_distinct idx %0d,%0d got %b want distinct", i, j,
                                 seen_q[i]);
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
